l1_buffer_addr_ctrl: RTL

L1_BUFFER_ADDR_CTRL -- requirements
Module: l1_buffer_addr_ctrl

---
 rtl/l1_buffer_addr_ctrl.sv | 68 ++++++
 1 files changed

// File: rtl/l1_buffer_addr_ctrl.sv
// l1_buffer_addr_ctrl: L1 buffer write/read address control with a readout event FSM and overflow accounting.
module l1_buffer_addr_ctrl #(
  parameter int ADDRWIDTH = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dis,
  input  logic                 L1A,
  input  logic                 evtDone,
  output logic [ADDRWIDTH-1:0] wrAddr,
  output logic                 wren,
  output logic [ADDRWIDTH-1:0] rdAddr,
  output logic                 preLoad,
  output logic                 load,
  output logic [ADDRWIDTH:0]   occupancy,
  output logic                 full,
  output logic                 empty,
  output logic                 evtBusy,
  output logic                 ovfPulse,
  output logic [7:0]           ovfCnt
);
  typedef enum logic [1:0] {S_IDLE, S_PRELOAD, S_LOAD, S_WAIT} state_t;
  state_t state, state_n;
  logic [ADDRWIDTH-1:0] wptr;
  logic accept, drop, done;
  // occupancy counts the event in service, so its slot cannot be reused before WAIT exit
  assign full    = occupancy == {1'b1, {ADDRWIDTH{1'b0}}};
  assign empty   = occupancy == '0;
  assign evtBusy = state != S_IDLE;
  assign accept  = !dis && L1A && !full;
  assign drop    = !dis && L1A && full;
  assign done    = !dis && state == S_WAIT && evtDone;
  always_comb begin
    state_n = state;
    if (!dis)
      case (state)
        S_IDLE:    state_n = empty ? S_IDLE : S_PRELOAD;
        S_PRELOAD: state_n = S_LOAD;
        S_LOAD:    state_n = S_WAIT;
        default:   state_n = evtDone ? S_IDLE : S_WAIT;
      endcase
  end
  always_ff @(posedge clk)
    if (!reset) state <= S_IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (!reset) begin
      wptr      <= '0;
      wrAddr    <= '0;
      rdAddr    <= '0;
      wren      <= 1'b0;
      preLoad   <= 1'b0;
      load      <= 1'b0;
      occupancy <= '0;
      ovfPulse  <= 1'b0;
      ovfCnt    <= '0;
    end else begin
      wren      <= accept;
      wrAddr    <= accept ? wptr : wrAddr;
      wptr      <= wptr + ADDRWIDTH'(accept);
      rdAddr    <= rdAddr + ADDRWIDTH'(done);
      occupancy <= occupancy + (ADDRWIDTH+1)'(accept) - (ADDRWIDTH+1)'(done);
      preLoad   <= !dis && state_n == S_PRELOAD;
      load      <= !dis && state_n == S_LOAD;
      ovfPulse  <= drop;
      ovfCnt    <= ovfCnt + 8'(drop && ovfCnt != 8'hff);
    end
endmodule
